// File: rtl/rom_access_arbiter.sv
// Shares the program ROM banks between the CPU bus and an auxiliary requester with round-robin grants.
// Ack and data appear ROM_LAT+1 cycles after the sampling edge; each port holds req until ack (4-phase).
module rom_access_arbiter #(
  parameter int          ROM_LAT    = 1,
  parameter int          RESET_HOLD = 31,
  parameter logic [15:0] UNMAPPED   = 16'hFFFF
) (
  input  logic        MCKR,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  output logic        cpu_ack,
  output logic [15:0] cpu_data,
  input  logic        aux_req,
  input  logic [22:0] aux_addr,
  output logic        aux_ack,
  output logic [15:0] aux_data,
  output logic        rom_en,
  output logic [16:0] rom_addr,
  output logic        rom_hsel,
  input  logic [15:0] rom_datah,
  input  logic [15:0] rom_datal,
  output logic        sys_rdy
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int WW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2, ACK = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [16:0]   addr_q, addr_d;
  logic          hsel_q, hsel_d;
  logic          unmap_q, unmap_d;
  logic          gnt_aux_q, gnt_aux_d;
  logic          last_aux_q, last_aux_d;
  logic          abort_q, abort_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          aux_ack_q, aux_ack_d;
  logic [15:0]   cpu_data_q, cpu_data_d;
  logic [15:0]   aux_data_q, aux_data_d;

  logic        rdy;
  logic        any_req;
  logic        gnt_req;
  logic        pick_aux;
  logic [22:0] sel_addr;
  logic [15:0] cap_data;

  assign rdy      = (hold_cnt_q == HW'(RESET_HOLD));
  assign any_req  = cpu_req | aux_req;
  assign gnt_req  = gnt_aux_q ? aux_req : cpu_req;
  // On a tie the port that was not served last wins.
  assign pick_aux = aux_req & (~cpu_req | ~last_aux_q);
  assign sel_addr = pick_aux ? aux_addr : cpu_addr;
  assign cap_data = unmap_q ? UNMAPPED : (hsel_q ? rom_datah : rom_datal);

  always_ff @(posedge MCKR) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      hsel_q     <= 1'b0;
      unmap_q    <= 1'b0;
      gnt_aux_q  <= 1'b0;
      last_aux_q <= 1'b1;
      abort_q    <= 1'b0;
      cpu_ack_q  <= 1'b0;
      aux_ack_q  <= 1'b0;
      cpu_data_q <= '0;
      aux_data_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      hsel_q     <= hsel_d;
      unmap_q    <= unmap_d;
      gnt_aux_q  <= gnt_aux_d;
      last_aux_q <= last_aux_d;
      abort_q    <= abort_d;
      cpu_ack_q  <= cpu_ack_d;
      aux_ack_q  <= aux_ack_d;
      cpu_data_q <= cpu_data_d;
      aux_data_q <= aux_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rdy && any_req) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    if (wcnt_q == '0) state_d = (gnt_req && !abort_q) ? ACK : IDLE;
      ACK:     if (!gnt_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d = rdy ? hold_cnt_q : hold_cnt_q + HW'(1);
    wcnt_d     = wcnt_q;
    addr_d     = addr_q;
    hsel_d     = hsel_q;
    unmap_d    = unmap_q;
    gnt_aux_d  = gnt_aux_q;
    last_aux_d = last_aux_q;
    abort_d    = abort_q;
    cpu_ack_d  = cpu_ack_q;
    aux_ack_d  = aux_ack_q;
    cpu_data_d = cpu_data_q;
    aux_data_d = aux_data_q;
    case (state_q)
      IDLE: begin
        if (rdy && any_req) begin
          gnt_aux_d = pick_aux;
          addr_d    = sel_addr[16:0];
          hsel_d    = sel_addr[18];
          unmap_d   = (|sel_addr[22:19]) | (sel_addr[18] & (|sel_addr[17:12]));
          abort_d   = 1'b0;
        end
      end
      READ: begin
        wcnt_d = WW'(ROM_LAT - 1);
        if (!gnt_req) abort_d = 1'b1;
      end
      WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WW'(1);
          if (!gnt_req) abort_d = 1'b1;
        end else if (gnt_req && !abort_q) begin
          if (gnt_aux_q) begin
            aux_data_d = cap_data;
            aux_ack_d  = 1'b1;
          end else begin
            cpu_data_d = cap_data;
            cpu_ack_d  = 1'b1;
          end
        end else begin
          // Abandoned read: the grant still counts for fairness.
          last_aux_d = gnt_aux_q;
        end
      end
      ACK: begin
        if (!gnt_req) begin
          cpu_ack_d  = 1'b0;
          aux_ack_d  = 1'b0;
          last_aux_d = gnt_aux_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rom_en   = (state_q == READ) && !unmap_q;
    rom_addr = addr_q;
    rom_hsel = hsel_q;
    cpu_ack  = cpu_ack_q;
    cpu_data = cpu_data_q;
    aux_ack  = aux_ack_q;
    aux_data = aux_data_q;
    sys_rdy  = rdy;
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Scoreboard bench: drivers push the expected read data per port, a negedge monitor pops on each ack rise.
module tb_rom_access_arbiter;
  localparam int HOLD = 31;
  localparam int TMO  = 120;

  logic        MCKR = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, aux_req = 1'b0;
  logic [22:0] cpu_addr = '0, aux_addr = '0;
  logic        cpu_ack, aux_ack, rom_en, rom_hsel, sys_rdy;
  logic [15:0] cpu_data, aux_data, rom_datah, rom_datal;
  logic [16:0] rom_addr;

  logic        c3_req = 1'b0, c3_aux_req = 1'b0;
  logic [22:0] c3_addr = '0, c3_aux_addr = '0;
  logic        c3_cpu_ack, c3_aux_ack, c3_rom_en, c3_rom_hsel, c3_sys_rdy;
  logic [15:0] c3_cpu_data, c3_aux_data, c3_datah, c3_datal;
  logic [16:0] c3_rom_addr;

  int checks = 0;
  int errors = 0;

  always #5 MCKR = ~MCKR;

  rom_access_arbiter #(.ROM_LAT(1), .RESET_HOLD(HOLD), .UNMAPPED(16'hFFFF)) dut (
    .MCKR(MCKR), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_ack(aux_ack), .aux_data(aux_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_hsel(rom_hsel),
    .rom_datah(rom_datah), .rom_datal(rom_datal), .sys_rdy(sys_rdy));

  rom_access_arbiter #(.ROM_LAT(3), .RESET_HOLD(HOLD), .UNMAPPED(16'hFFFF)) dut3 (
    .MCKR(MCKR), .reset(reset),
    .cpu_req(c3_req), .cpu_addr(c3_addr), .cpu_ack(c3_cpu_ack), .cpu_data(c3_cpu_data),
    .aux_req(c3_aux_req), .aux_addr(c3_aux_addr), .aux_ack(c3_aux_ack), .aux_data(c3_aux_data),
    .rom_en(c3_rom_en), .rom_addr(c3_rom_addr), .rom_hsel(c3_rom_hsel),
    .rom_datah(c3_datah), .rom_datal(c3_datal), .sys_rdy(c3_sys_rdy));

  // ROM contents: a few pinned words, everything else a fixed function of the address.
  logic [15:0] mem_l [int];
  logic [15:0] mem_h [int];

  function automatic logic [15:0] rom_l(input logic [16:0] a);
    if (mem_l.exists(int'(a))) return mem_l[int'(a)];
    return a[15:0] ^ 16'h3C5A ^ {a[16], 15'h0};
  endfunction

  function automatic logic [15:0] rom_h(input logic [11:0] a);
    if (mem_h.exists(int'(a))) return mem_h[int'(a)];
    return {4'hB, a ^ 12'h5A5};
  endfunction

  function automatic logic [15:0] exp_data(input logic [22:0] a);
    if (a[22:19] != 4'h0 || (a[18] && a[17:12] != 6'h0)) return 16'hFFFF;
    if (a[18]) return rom_h(a[11:0]);
    return rom_l(a[16:0]);
  endfunction

  // ROM models: valid data only ROM_LAT cycles after a strobe, noise otherwise.
  always @(posedge MCKR) begin
    rom_datah <= rom_en ? rom_h(rom_addr[11:0]) : 16'($urandom);
    rom_datal <= rom_en ? rom_l(rom_addr) : 16'($urandom);
  end

  logic [15:0] p3h [3];
  logic [15:0] p3l [3];
  always @(posedge MCKR) begin
    p3h[0] <= c3_rom_en ? rom_h(c3_rom_addr[11:0]) : 16'($urandom);
    p3l[0] <= c3_rom_en ? rom_l(c3_rom_addr) : 16'($urandom);
    p3h[1] <= p3h[0];
    p3l[1] <= p3l[0];
    p3h[2] <= p3h[1];
    p3l[2] <= p3l[1];
  end
  assign c3_datah = p3h[2];
  assign c3_datal = p3l[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Scoreboard and protocol monitor.
  logic [15:0] exp_cpu [$];
  logic [15:0] exp_aux [$];
  bit          grant_log [$];
  int          rom_en_cnt = 0;
  logic [16:0] last_rom_addr = '0;
  logic        last_hsel = 1'b0;
  logic        rst_at_edge = 1'b1;
  logic        cpu_ack_p = 1'b0, aux_ack_p = 1'b0, rom_en_p = 1'b0;
  logic [15:0] cpu_data_p = '0, aux_data_p = '0;

  always @(posedge MCKR) rst_at_edge <= reset;

  always @(negedge MCKR) begin
    logic [15:0] e;
    if (cpu_ack || aux_ack) chk("ack_overlap", {cpu_ack, aux_ack} == 2'b11, 1'b0);
    if (rom_en) begin
      rom_en_cnt++;
      last_rom_addr = rom_addr;
      last_hsel     = rom_hsel;
      chk("rom_en_before_rdy", sys_rdy, 1'b1);
      chk("rom_en_width", rom_en_p, 1'b0);
    end
    if (cpu_ack && !cpu_ack_p) begin
      grant_log.push_back(1'b0);
      if (exp_cpu.size() == 0) chk("cpu_unexpected_ack", cpu_ack, 1'b0);
      else begin
        e = exp_cpu.pop_front();
        chk("cpu_data", cpu_data, e);
      end
    end else if (!rst_at_edge) chk("cpu_data_hold", cpu_data, cpu_data_p);
    if (aux_ack && !aux_ack_p) begin
      grant_log.push_back(1'b1);
      if (exp_aux.size() == 0) chk("aux_unexpected_ack", aux_ack, 1'b0);
      else begin
        e = exp_aux.pop_front();
        chk("aux_data", aux_data, e);
      end
    end else if (!rst_at_edge) chk("aux_data_hold", aux_data, aux_data_p);
    cpu_ack_p  = cpu_ack;
    aux_ack_p  = aux_ack;
    rom_en_p   = rom_en;
    cpu_data_p = cpu_data;
    aux_data_p = aux_data;
  end

  function automatic logic ack_of(input bit port);
    return port ? aux_ack : cpu_ack;
  endfunction

  // One 4-phase read. Called at a negedge; abort_after>0 drops req that many cycles in if no ack yet.
  // lat counts cycles from the sampling edge to ack, meaningful when the grant is immediate.
  task automatic do_txn(input bit port, input logic [22:0] addr, input int abort_after,
                        input int hold_extra, output bit acked, output int lat);
    int n;
    logic [15:0] e;
    acked = 1'b0;
    lat   = -1;
    n     = 0;
    while (ack_of(port) && n < TMO) begin
      @(negedge MCKR);
      n++;
    end
    if (n >= TMO) begin
      chk("ack_idle_timeout", ack_of(port), 1'b0);
      return;
    end
    e = exp_data(addr);
    if (port) begin aux_addr = addr; aux_req = 1'b1; exp_aux.push_back(e); end
    else      begin cpu_addr = addr; cpu_req = 1'b1; exp_cpu.push_back(e); end
    n = 0;
    while (1) begin
      @(negedge MCKR);
      n++;
      if (ack_of(port)) begin
        acked = 1'b1;
        lat   = n - 1;
        break;
      end
      if ((abort_after > 0 && n == abort_after) || n >= TMO) begin
        if (n >= TMO) chk("ack_timeout", 1'b0, 1'b1);
        if (port) begin aux_req = 1'b0; e = exp_aux.pop_back(); end
        else      begin cpu_req = 1'b0; e = exp_cpu.pop_back(); end
        repeat (6) @(negedge MCKR);
        return;
      end
    end
    repeat (hold_extra) @(negedge MCKR);
    if (port) aux_req = 1'b0; else cpu_req = 1'b0;
    @(negedge MCKR);
    chk(port ? "aux_ack_fall" : "cpu_ack_fall", ack_of(port), 1'b0);
  endtask

  // Called at a negedge: one reset cycle, checks cleared outputs, returns cycles until sys_rdy.
  task automatic do_reset(output int cyc);
    reset = 1'b1;
    @(negedge MCKR);
    chk("reset_outputs", {cpu_ack, aux_ack, rom_en, rom_hsel, sys_rdy, cpu_data, aux_data, rom_addr}, 64'h0);
    reset = 1'b0;
    cyc = 0;
    while (cyc < TMO) begin
      @(posedge MCKR);
      #1;
      cyc++;
      if (sys_rdy) break;
    end
    @(negedge MCKR);
  endtask

  function automatic logic [22:0] rand_addr();
    logic [22:0] a;
    int k;
    a = 23'($urandom);
    k = int'($urandom_range(0, 3));
    if (k < 2) a[22:18] = 5'b0;
    else if (k == 2) begin a[22:18] = 5'b00001; a[17:12] = 6'h0; end
    else if ($urandom_range(0, 1) == 1) a[22:19] = 4'($urandom_range(1, 15));
    else begin a[22:18] = 5'b00001; a[17:12] = 6'($urandom_range(1, 63)); end
    return a;
  endfunction

  task automatic rand_port(input bit port, input int count);
    bit ok;
    int lat, ab;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge MCKR);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_txn(port, rand_addr(), ab, int'($urandom_range(0, 2)), ok, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok1, ok2;
    int lat1, lat2, cyc, r0, n;
    logic [15:0] e;
    mem_l[int'(17'h00010)] = 16'h4E71;
    mem_h[int'(12'hABC)]   = 16'h1234;
    @(negedge MCKR);

    // Both requests held through reset: hold time, then CPU wins the first tie.
    fork
      begin do_reset(cyc); chk("hold_cycles", cyc, HOLD); end
      do_txn(1'b0, 23'h000123, 0, 1, ok1, lat1);
      do_txn(1'b1, 23'h040321, 0, 1, ok2, lat2);
    join
    chk("first_grant_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) chk("first_grant_order", {grant_log[0], grant_log[1]}, 2'b01);

    // Back-to-back requests on both ports alternate.
    grant_log.delete();
    fork
      begin
        do_txn(1'b0, 23'h001000, 0, 0, ok1, lat1);
        do_txn(1'b0, 23'h040002, 0, 0, ok1, lat1);
      end
      begin
        do_txn(1'b1, 23'h00ABCD, 0, 0, ok2, lat2);
        do_txn(1'b1, 23'h01FFFF, 0, 0, ok2, lat2);
      end
    join
    chk("alt_count", grant_log.size(), 4);
    if (grant_log.size() >= 4)
      chk("alt_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);

    // Low-bank read with pinned data.
    r0 = rom_en_cnt;
    do_txn(1'b0, 23'h000010, 0, 1, ok1, lat1);
    chk("low_latency", lat1, 2);
    chk("low_rom_en_pulses", rom_en_cnt - r0, 1);
    chk("low_rom_addr", last_rom_addr, 17'h00010);
    chk("low_hsel", last_hsel, 1'b0);
    chk("low_cpu_data", cpu_data, 16'h4E71);

    // High-bank read on aux leaves cpu_data alone.
    do_txn(1'b1, 23'h040ABC, 0, 0, ok2, lat2);
    chk("high_latency", lat2, 2);
    chk("high_hsel", last_hsel, 1'b1);
    chk("high_rom_addr", last_rom_addr[11:0], 12'hABC);
    chk("high_aux_data", aux_data, 16'h1234);
    chk("high_cpu_data_kept", cpu_data, 16'h4E71);

    // Unmapped read: no strobe, fill value, same latency.
    r0 = rom_en_cnt;
    do_txn(1'b0, 23'h100000, 0, 0, ok1, lat1);
    chk("unmapped_latency", lat1, 2);
    chk("unmapped_no_rom_en", rom_en_cnt - r0, 0);
    chk("unmapped_data", cpu_data, 16'hFFFF);

    // Tie after a CPU grant goes to AUX.
    grant_log.delete();
    fork
      do_txn(1'b0, 23'h000777, 0, 0, ok1, lat1);
      do_txn(1'b1, 23'h040777, 0, 0, ok2, lat2);
    join
    chk("tie_count", grant_log.size(), 2);
    if (grant_log.size() >= 2) chk("tie_order", {grant_log[0], grant_log[1]}, 2'b10);

    // Abort during READ: no ack, and the next request is served at normal latency.
    do_txn(1'b0, 23'h000400, 1, 0, ok1, lat1);
    chk("abort_no_ack", ok1, 1'b0);
    do_txn(1'b1, 23'h000500, 0, 0, ok2, lat2);
    chk("after_abort_ack", ok2, 1'b1);
    chk("after_abort_latency", lat2, 2);

    // Reset during WAIT; the still-held request is served after the new hold.
    e = exp_data(23'h000200);
    exp_cpu.push_back(e);
    cpu_addr = 23'h000200;
    cpu_req  = 1'b1;
    @(negedge MCKR);
    @(negedge MCKR);
    do_reset(cyc);
    chk("rehold_cycles", cyc, HOLD);
    n = 0;
    while (!cpu_ack && n < TMO) begin
      @(negedge MCKR);
      n++;
    end
    chk("reset_retry_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    @(negedge MCKR);
    chk("reset_retry_ack_fall", cpu_ack, 1'b0);

    // Three-cycle ROM: ack four cycles after sampling.
    c3_addr = 23'h00C0DE;
    c3_req  = 1'b1;
    n = 0;
    while (!c3_cpu_ack && n < TMO) begin
      @(negedge MCKR);
      n++;
    end
    chk("lat3_latency", n - 1, 4);
    chk("lat3_data", c3_cpu_data, exp_data(23'h00C0DE));
    c3_req = 1'b0;
    @(negedge MCKR);
    chk("lat3_ack_fall", c3_cpu_ack, 1'b0);

    // Randomised traffic on both ports.
    fork
      rand_port(1'b0, 40);
      rand_port(1'b1, 40);
    join
    repeat (10) @(negedge MCKR);
    chk("cpu_queue_empty", exp_cpu.size(), 0);
    chk("aux_queue_empty", exp_aux.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
